cpu_fetch_decode: RTL and testbench
===================================

Name: cpu_fetch_decode

Overview:
- Upstream control stage for cpu_data_path.
- Owns the architectural PC and fetches 16-bit instruction words over the APB bus as master.
- Decodes each word into the datapath control vector, issues it with a one-cycle begin_instruction pulse, then waits for the next_IR completion handshake before fetching again.
- The only APB master while the datapath is idle; it never drives the bus while an instruction is in flight.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- TIMEOUT_CYCLES, 16, maximum pready wait per fetch; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- run  input  1  level; fetching proceeds only while high.
- paddr  output  16  APB address (= PC during fetch).
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  always 0 (fetch is read-only).
- prdata  input  16  APB read data.
- pready  input  1  APB ready.
- next_IR  input  1  datapath completion flag.
- PC_in  input  16  next PC from datapath (its PC_out).
- IR  output  16  issued instruction word.
- PC  output  16  architectural PC of issued instruction.
- begin_instruction  output  1  one-cycle issue strobe.
- rf_wr_sel, reg_1_sel, reg_2_sel  output  3 each  register selects.
- ALU_sel  output  3  ALU operation.
- PC_sel, R1_sel, R2_sel, rf_write_sel, write_rf_bool  output  1 each  datapath mux controls.
- halted  output  1  HALT executed or fetch fault.
- illegal_op  output  1  one-cycle pulse on undefined opcode.

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC; IR=0; all control outputs 0; psel=penable=pwrite=0; begin_instruction=0; halted=0; illegal_op=0; state IDLE. Reset mid-transfer drops psel/penable immediately.
- IR fields: op=IR[15:12], rd=IR[11:9], rs1=IR[8:6], rs2=IR[5:3].
- rf_wr_sel=rd, reg_1_sel=rs1, reg_2_sel=rs2 for all opcodes.
- States:
  - IDLE: go to SETUP when run=1 and halted=0.
  - SETUP: psel=1, penable=0, paddr=PC. Next cycle goes to ACCESS.
  - ACCESS: psel=1, penable=1. When pready=1, capture prdata into the fetch latch, deassert psel/penable, go to DECODE.
  - DECODE: drive the control vector from the latched word. op=F: set halted, go to IDLE. Otherwise go to ISSUE.
  - ISSUE: IR and controls stable; begin_instruction=1 for exactly this cycle; go to WAIT_LO.
  - WAIT_LO: wait for next_IR=0 (datapath accepted), then go to WAIT_HI.
  - WAIT_HI: on next_IR=1, PC<=PC_in; go to SETUP if run=1, else IDLE.
- Control outputs hold from DECODE until the next DECODE.
- Minimum latency from fetch start to begin_instruction: 4 cycles with zero-wait pready.
- Decode map; unlisted controls are 0:
  - 0 NOP: no controls set.
  - 1 ADD: ALU 000, rf_write_sel=1, write_rf_bool=1.
  - 2 SUB: as ADD, ALU 001.
  - 3 AND: as ADD, ALU 010.
  - 4 OR: as ADD, ALU 011.
  - 5 ADDI: ALU 100, R2_sel=1, rf_write_sel=1, write_rf_bool=1.
  - 6 LD: ALU 101, rf_write_sel=1, write_rf_bool=1.
  - 7 ST: ALU 110.
  - 8 JMP: ALU 100, R1_sel=1, R2_sel=1, PC_sel=1.
  - F HALT: no issue.
  - 9..E: decoded as NOP and issued; illegal_op pulses in DECODE.
- halted is sticky; cleared only by reset.
- run low during a fetch or wait does not abort it; the block parks in IDLE at the next SETUP decision point.
- PC arithmetic is owned by the datapath; PC_in is taken verbatim, and 16'hFFFF+1 wraps to 0.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. If pready stays low for TIMEOUT_CYCLES consecutive cycles, drop psel/penable, set halted, go to IDLE; PC unchanged.
- Undefined: ACCESS waits for pready indefinitely; no counter is synthesized.

Test Plan:
- Reset with RESET_PC=16'h0010, run=1, zero-wait memory holding 16'h1298 at 0x0010 -> paddr=0x0010; begin_instruction at cycle 4; rf_wr_sel=1, reg_1_sel=2, reg_2_sel=3, ALU_sel=000, write_rf_bool=1.
- next_IR low then high with PC_in=0x0011 -> next fetch paddr=0x0011.
- 3-cycle pready stall -> psel/penable held; begin_instruction delayed exactly 3 cycles.
- Word 16'hF000 -> halted=1, no begin_instruction, bus idle thereafter.
- Word 16'hA000 -> illegal_op one-cycle pulse; issued with all controls 0.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready tied 0 -> halted after 16 ACCESS cycles, psel=0; reset_n low mid-ACCESS -> psel=0 asynchronously.

Source files
------------

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode control stage: owns the PC, fetches over APB, decodes, issues to the datapath.
// Optional FETCH_TIMEOUT_EN halts the core if a fetch waits on pready for TIMEOUT_CYCLES.
module cpu_fetch_decode #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic [15:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    input  logic [15:0] prdata,
    input  logic        pready,
    input  logic        next_IR,
    input  logic [15:0] PC_in,
    output logic [15:0] IR,
    output logic [15:0] PC,
    output logic        begin_instruction,
    output logic [2:0]  rf_wr_sel,
    output logic [2:0]  reg_1_sel,
    output logic [2:0]  reg_2_sel,
    output logic [2:0]  ALU_sel,
    output logic        PC_sel,
    output logic        R1_sel,
    output logic        R2_sel,
    output logic        rf_write_sel,
    output logic        write_rf_bool,
    output logic        halted,
    output logic        illegal_op
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_DECODE  = 3'd3;
    localparam logic [2:0] S_ISSUE   = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;
    localparam logic [2:0] S_WAIT_HI = 3'd6;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        halted_q, halted_d;
    logic [3:0]  op;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
`endif

    assign op = ir_q[15:12];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_d    = '0;
`endif
        case (state_q)
            S_IDLE:   if (run && !halted_q) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    ir_d    = prdata;
                    state_d = S_DECODE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    halted_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            S_DECODE: begin
                if (op == 4'hF) begin
                    halted_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_WAIT_LO;
            S_WAIT_LO: if (!next_IR) state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (next_IR) begin
                    pc_d    = PC_in;
                    state_d = run ? S_SETUP : S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Controls decode straight from the fetch latch, which only changes on entry to DECODE,
    // so they hold from one DECODE to the next.
    always_comb begin
        ALU_sel       = 3'b000;
        PC_sel        = 1'b0;
        R1_sel        = 1'b0;
        R2_sel        = 1'b0;
        rf_write_sel  = 1'b0;
        write_rf_bool = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4: begin
                ALU_sel       = 3'(op - 4'h1);
                rf_write_sel  = 1'b1;
                write_rf_bool = 1'b1;
            end
            4'h5: begin
                ALU_sel       = 3'b100;
                R2_sel        = 1'b1;
                rf_write_sel  = 1'b1;
                write_rf_bool = 1'b1;
            end
            4'h6: begin
                ALU_sel       = 3'b101;
                rf_write_sel  = 1'b1;
                write_rf_bool = 1'b1;
            end
            4'h7: ALU_sel = 3'b110;
            4'h8: begin
                ALU_sel = 3'b100;
                R1_sel  = 1'b1;
                R2_sel  = 1'b1;
                PC_sel  = 1'b1;
            end
            default: ;
        endcase
    end

    assign rf_wr_sel         = ir_q[11:9];
    assign reg_1_sel         = ir_q[8:6];
    assign reg_2_sel         = ir_q[5:3];
    assign IR                = ir_q;
    assign PC                = pc_q;
    assign paddr             = pc_q;
    assign psel              = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable           = (state_q == S_ACCESS);
    assign pwrite            = 1'b0;
    assign begin_instruction = (state_q == S_ISSUE);
    assign halted            = halted_q;
    assign illegal_op        = (state_q == S_DECODE) && (op >= 4'h9) && (op <= 4'hE);

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Scoreboard bench for cpu_fetch_decode: zero/stalled-wait APB memory model plus datapath handshake.
module tb_cpu_fetch_decode;

    logic        clk = 1'b0;
    logic        reset_n, run, pready, next_IR;
    logic [15:0] prdata, PC_in, paddr, IR, PC;
    logic        psel, penable, pwrite, begin_instruction;
    logic [2:0]  rf_wr_sel, reg_1_sel, reg_2_sel, ALU_sel;
    logic        PC_sel, R1_sel, R2_sel, rf_write_sel, write_rf_bool, halted, illegal_op;

    always #5 clk = ~clk;

    cpu_fetch_decode #(.RESET_PC(16'h0010), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .prdata(prdata), .pready(pready),
        .next_IR(next_IR), .PC_in(PC_in), .IR(IR), .PC(PC),
        .begin_instruction(begin_instruction),
        .rf_wr_sel(rf_wr_sel), .reg_1_sel(reg_1_sel), .reg_2_sel(reg_2_sel),
        .ALU_sel(ALU_sel), .PC_sel(PC_sel), .R1_sel(R1_sel), .R2_sel(R2_sel),
        .rf_write_sel(rf_write_sel), .write_rf_bool(write_rf_bool),
        .halted(halted), .illegal_op(illegal_op)
    );

    logic [15:0] mem [0:255];
    assign prdata = mem[paddr[7:0]];

    typedef struct { logic [15:0] pc; logic [15:0] ir; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {ALU_sel[2:0], PC_sel, R1_sel, R2_sel, rf_write_sel, write_rf_bool}
    function automatic logic [7:0] ref_ctrl(input logic [3:0] op);
        case (op)
            4'h1:    return 8'b000_0_0_0_1_1;
            4'h2:    return 8'b001_0_0_0_1_1;
            4'h3:    return 8'b010_0_0_0_1_1;
            4'h4:    return 8'b011_0_0_0_1_1;
            4'h5:    return 8'b100_0_0_1_1_1;
            4'h6:    return 8'b101_0_0_0_1_1;
            4'h7:    return 8'b110_0_0_0_0_0;
            4'h8:    return 8'b100_1_1_1_0_0;
            default: return 8'b000_0_0_0_0_0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'h9) && (op <= 4'hE);
    endfunction

    // Issue monitor: every begin_instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && begin_instruction) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("issue_IR", IR, e.ir);
                chk("issue_PC", PC, e.pc);
                chk("rf_wr_sel", rf_wr_sel, e.ir[11:9]);
                chk("reg_1_sel", reg_1_sel, e.ir[8:6]);
                chk("reg_2_sel", reg_2_sel, e.ir[5:3]);
                chk("ctrl_vec", {ALU_sel, PC_sel, R1_sel, R2_sel, rf_write_sel, write_rf_bool},
                    ref_ctrl(e.ir[15:12]));
            end
        end
    end

    task automatic wait_setup(input logic [15:0] pc);
        int n = 0;
        while (!(psel && !penable) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("setup_seen", psel && !penable, 1'b1);
        chk("setup_paddr", paddr, pc);
        chk("pwrite", pwrite, 1'b0);
    endtask

    task automatic fetch_one(input logic [15:0] pc, input logic [15:0] npc, input int stall);
        int lat, st;
        logic [15:0] w;
        w = mem[pc[7:0]];
        sb.push_back('{pc, w});
        wait_setup(pc);
        st  = stall;
        lat = 1;
        while (!begin_instruction && lat < 30) begin
            @(negedge clk);
            lat++;
            if (psel && penable) begin
                if (st > 0) begin
                    chk("stall_hold_paddr", paddr, pc);
                    pready = 1'b0;
                    st--;
                end else begin
                    pready = 1'b1;
                end
            end
            chk("illegal_op", illegal_op, (lat == 3 + stall) && is_illegal(w[15:12]));
        end
        pready = 1'b1;
        chk("issue_latency", lat, 4 + stall);
        next_IR = 1'b0;
        @(negedge clk);
        chk("illegal_after_issue", illegal_op, 1'b0);
        chk("bus_idle_wait", psel, 1'b0);
        @(negedge clk);
        chk("bus_idle_wait", psel, 1'b0);
        next_IR = 1'b1;
        PC_in   = npc;
    endtask

    logic [15:0] t_pc   [11] = '{16'h0010, 16'h0011, 16'h0012, 16'hFFFF, 16'h0000, 16'h0001,
                                 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    logic [15:0] t_word [11] = '{16'h1298, 16'hA000, 16'h5A50, 16'h8E40, 16'h7123, 16'h2C88,
                                 16'h3111, 16'h4222, 16'h6333, 16'h0FFF, 16'hF000};
    int          t_stall[11] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 11; i++) mem[t_pc[i][7:0]] = t_word[i];
        reset_n = 1'b0;
        run     = 1'b1;
        pready  = 1'b1;
        next_IR = 1'b1;
        PC_in   = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_begin", begin_instruction, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_illegal", illegal_op, 1'b0);
        chk("rst_IR", IR, 16'h0000);
        chk("rst_PC", PC, 16'h0010);
        chk("rst_ctrl", {ALU_sel, PC_sel, R1_sel, R2_sel, rf_write_sel, write_rf_bool}, 8'h00);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) fetch_one(t_pc[i], t_pc[i+1], t_stall[i]);

        // HALT: no issue, halted sticky, bus stays idle
        wait_setup(16'h0006);
        repeat (2) @(negedge clk);
        chk("halt_not_yet", halted, 1'b0);
        @(negedge clk);
        chk("halted_set", halted, 1'b1);
        chk("halt_no_issue", begin_instruction, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_bus_idle", psel, 1'b0);
        end
        chk("halted_sticky", halted, 1'b1);
        chk("sb_drained", sb.size(), 0);

        // Reset mid-ACCESS drops the bus without waiting for a clock edge
        reset_n = 1'b0;
        #1;
        chk("rst_clears_halt", halted, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        pready  = 1'b0;
        begin
            int n = 0;
            while (!(psel && penable) && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("in_access", psel && penable, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_psel", psel, 1'b0);
        chk("async_rst_penable", penable, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        @(negedge clk);
        reset_n = 1'b1;
        wait_setup(16'h0010);
        begin
            int cnt = 0;
            @(negedge clk);
            while (psel && penable && cnt < 40) begin
                cnt++;
                @(negedge clk);
            end
            chk("timeout_cycles", cnt, 16);
        end
        chk("timeout_halted", halted, 1'b1);
        chk("timeout_psel", psel, 1'b0);
        chk("timeout_pc", paddr, 16'h0010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
